// File: rtl/invaes_pkg.sv
// Shared types and constants for the inverse-AES SPI front end.
package invaes_pkg;

    localparam int BLOCK_W    = 128;
    localparam int FRAME_BITS = 256;
    localparam int CNT_W      = 9;

    // Synchronizer lane assignment
    localparam int LN_SCK  = 0;
    localparam int LN_SDI  = 1;
    localparam int LN_LOAD = 2;
    localparam int LN_DONE = 3;
    localparam int NUM_LN  = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT_IN  = 2'd1,
        WAIT_CORE = 2'd2,
        SHIFT_OUT = 2'd3
    } spi_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/invaes_spi_if_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, plus single-cycle rise/fall pulses.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/invaes_spi_if.sv
// SPI slave front end for the inverse-AES core: shifts in {key, cyphertext}, waits for
// the core, shifts plaintext back out. Optional bit-count check: INVAES_SPI_FRAMECHK_EN.
module invaes_spi_if
    import invaes_pkg::*;
#(
    parameter int K           = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sck,
    input  logic               sdi,
    output logic               sdo,
    input  logic               load,
    input  logic               done_in,
    input  logic [BLOCK_W-1:0] plaintext,
    output logic               ce,
    output logic [K-1:0]       key,
    output logic [BLOCK_W-1:0] cyphertext,
    output logic               done,
    output logic               frame_err
);

    logic [NUM_LN-1:0] pins, syn, rise, fall;

    assign pins = {done_in, load, sdi, sck};

    generate
        for (genvar i = 0; i < NUM_LN; i++) begin : g_sync
            sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
                .clk   (clk),
                .reset (reset),
                .d     (pins[i]),
                .q     (syn[i]),
                .rise  (rise[i]),
                .fall  (fall[i])
            );
        end
    endgenerate

    logic sck_rise, sck_fall, sdi_s, load_rise, load_fall, done_rise;

    assign sck_rise  = rise[LN_SCK];
    assign sck_fall  = fall[LN_SCK];
    assign sdi_s     = syn[LN_SDI];
    assign load_rise = rise[LN_LOAD];
    assign load_fall = fall[LN_LOAD];
    assign done_rise = rise[LN_DONE];

    logic unused_sync;
    assign unused_sync = ^{syn[LN_SCK], syn[LN_LOAD], syn[LN_DONE],
                           rise[LN_SDI], fall[LN_SDI], fall[LN_LOAD] & 1'b0, fall[LN_DONE]};

    spi_state_t            state;
    logic [FRAME_BITS-1:0] in_sr;
    logic [BLOCK_W-1:0]    out_sr;
    logic                  frame_bad;

    // A load edge always wins over any sck edge seen in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            in_sr  <= '0;
            out_sr <= '0;
            done   <= 1'b0;
        end else if (load_rise) begin
            state  <= SHIFT_IN;
            in_sr  <= '0;
            done   <= 1'b0;
        end else begin
            case (state)
                SHIFT_IN: begin
                    if (load_fall)
                        state <= frame_bad ? IDLE : WAIT_CORE;
                    else if (sck_rise)
                        in_sr <= {in_sr[FRAME_BITS-2:0], sdi_s};
                end
                WAIT_CORE: begin
                    if (done_rise) begin
                        state  <= SHIFT_OUT;
                        out_sr <= plaintext;
                        done   <= 1'b1;
                    end
                end
                SHIFT_OUT: begin
                    if (sck_fall)
                        out_sr <= {out_sr[BLOCK_W-2:0], 1'b0};
                end
                default: ;
            endcase
        end
    end

`ifdef INVAES_SPI_FRAMECHK_EN
    logic [CNT_W-1:0] bit_cnt;
    logic             ferr_r;

    assign frame_bad = (bit_cnt != CNT_W'(FRAME_BITS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= '0;
            ferr_r  <= 1'b0;
        end else if (load_rise) begin
            bit_cnt <= '0;
            ferr_r  <= 1'b0;
        end else if (state == SHIFT_IN) begin
            if (load_fall)
                ferr_r <= frame_bad;
            else if (sck_rise)
                bit_cnt <= sat_inc(bit_cnt);
        end
    end

    assign frame_err = ferr_r;
`else
    assign frame_bad = 1'b0;
    assign frame_err = 1'b0;
`endif

    // sdo is gated so a stale output register never leaks after an abort.
    assign ce         = (state == SHIFT_IN);
    assign sdo        = (state == SHIFT_OUT) & out_sr[BLOCK_W-1];
    assign key        = in_sr[FRAME_BITS-1 -: K];
    assign cyphertext = in_sr[BLOCK_W-1:0];

endmodule

// File: doc/invaes_spi_if.md
# invaes_spi_if

Serial front end for the inverse-AES datapath. The Raspberry Pi drives it as an SPI master. It shifts in a 128-bit key followed by 128-bit cyphertext, drives the decryption core's load/enable, and waits for the core's done. It then captures the 128-bit plaintext and shifts it back out on the same SPI link. All SPI signals are oversampled in the system clock domain; there is no second clock.

## Interface
- `K`, default 128: key width; only 128 is supported by this block.
- `SYNC_STAGES`, default 2: flops in each input synchronizer (sck, sdi, load, done_in); legal range 2–3.

- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `sck`, input, 1: SPI clock from Pi, asynchronous to `clk`.
- `sdi`, input, 1: SPI data from Pi; MSB first.
- `sdo`, output, 1: SPI data to Pi; MSB first.
- `load`, input, 1: Pi frame/load strobe; high while key and cyphertext are being shifted in.
- `done_in`, input, 1: done from the decryption core.
- `plaintext`, input, 128: result from the core.
- `ce`, output, 1: load/enable to the core.
- `key`, output, K: key to the core.
- `cyphertext`, output, 128: cyphertext to the core.
- `done`, output, 1: plaintext ready, to Pi.
- `frame_err`, output, 1: bit-count error flag (see Configuration).

## Operation
- FSM states: IDLE, SHIFT_IN, WAIT_CORE, SHIFT_OUT.
- IDLE → SHIFT_IN on synced `load` rising.
  - Any state → SHIFT_IN on synced `load` rising, so a new frame aborts the current one.
  - Entering SHIFT_IN clears `done` and the input shift register.
- SHIFT_IN:
  - `ce`=1.
  - On each detected sck rising edge, the 256-bit input register shifts left with synced `sdi` entering at bit 0.
  - After 256 bits the register holds `{key, cyphertext}`, so `key`=[255:128] and `cyphertext`=[127:0].
- SHIFT_IN → WAIT_CORE on synced `load` falling; `ce`=0 from that cycle.
  - `key`/`cyphertext` hold their values until the next SHIFT_IN.
- WAIT_CORE → SHIFT_OUT on synced `done_in` rising edge.
  - The edge is detected after synchronization; a level already high on entry is ignored.
  - On the transition cycle, `plaintext` is loaded into the 128-bit output register and `done` is set to 1.
- SHIFT_OUT:
  - `sdo` = output register [127].
  - On each detected sck falling edge, the output register shifts left with 0 filling bit 0.
  - Bits beyond 128 read 0.
- SHIFT_OUT → IDLE: never on its own; the FSM stays in SHIFT_OUT until the next `load` rising.
- An sck edge detected in the same cycle as a `load` edge is ignored.
- sck edges are ignored outside SHIFT_IN and SHIFT_OUT.
- Reset values: every register and output is 0 (FSM=IDLE, `ce`=0, `done`=0, `sdo`=0, `key`=0, `cyphertext`=0, `frame_err`=0).
- Reset asserted mid-frame clears all state immediately; the partial frame is discarded.

## Timing
- Synchronized sck/sdi/load/done_in are valid `SYNC_STAGES` cycles after the pin changes.
- Edge detection adds 1 cycle, so a shift happens `SYNC_STAGES`+1 clk cycles after the sck pin edge.
- Pi requirements:
  - sck high and low phases ≥ `SYNC_STAGES`+2 clk periods each.
  - sdi stable across that window.
- `ce` tracks `load` with `SYNC_STAGES`+1 cycles of latency.
- `done` rises `SYNC_STAGES`+1 cycles after the `done_in` pin rises.
- `sdo` changes 1 cycle after the detected falling edge.

## Configuration
- `INVAES_SPI_FRAMECHK_EN` defined:
  - A 9-bit counter counts sck rising edges in SHIFT_IN; it saturates at 511.
  - On `load` falling, `frame_err` is set if count ≠ 256.
    - When `frame_err` is set, the FSM goes to IDLE instead of WAIT_CORE, and `ce` is not pulsed again.
    - Recovery is via the next `load` rising.
  - `frame_err` clears on `load` rising.
- Macro undefined: no counter; `frame_err` is tied to 0; `load` falling always goes to WAIT_CORE.

## Structure
- Shared package `invaes_pkg`:
  - state enum `spi_state_t`;
  - constants `BLOCK_W`=128 and `FRAME_BITS`=256.
- One sub-module `sync_edge`: a `SYNC_STAGES`-deep synchronizer with `rise`/`fall` pulse outputs.
  - Instantiated for sck, load and done_in; sdi uses the synchronizer only.
- The FSM and shift registers live in the top module.

## Test plan
- FIPS-197 C.1 load: key 000102030405060708090a0b0c0d0e0f, cyphertext 69c4e0d86a7b0430d8cdb78070b4c55a → `key`/`cyphertext` match exactly after `load` falls; `ce` high only during the frame.
- Core model asserts `done_in` with plaintext 00112233445566778899aabbccddeeff → `done`=1 after 3 cycles; 128 falling sck edges shift out exactly that value on `sdo`.
- Reset low at bit 100 of the input frame → all outputs 0 the same cycle; a fresh full frame afterwards decrypts correctly.
- New `load` rise during SHIFT_OUT at bit 40 → `done` clears and SHIFT_IN restarts; the old plaintext is not output further.
- `done_in` already high on entry to WAIT_CORE, then low, then high → `done` rises only on the second rising edge.
- With `INVAES_SPI_FRAMECHK_EN`: a 255-bit frame → `frame_err`=1 and FSM returns to IDLE; a following 256-bit frame → `frame_err`=0 and normal flow.
